// File: rtl/control_unit_seq.sv
// Multi-cycle fetch/decode/execute/writeback control unit with integrated instruction register.
// Optional CU_SINGLE_STEP_EN adds a step input and a PAUSE state between instructions.
module control_unit_seq #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned REG_AW = 2,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
`ifdef CU_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic                   mem_rd_req,
    input  logic                   mem_rd_valid,
    input  logic [DWIDTH-1:0]      mem_rdata,
    output logic                   alu_start,
    input  logic                   alu_done,
    input  logic                   alu_zero,
    output logic [2:0]             alu_func,
    output logic                   alu_in_sel,
    output logic [REG_AW-1:0]      rs_sel,
    output logic [2**REG_AW-1:0]   reg_we,
    output logic [ADDR_W-1:0]      imm,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic                   busy,
    output logic                   halted
);

    localparam int unsigned NREG = 2**REG_AW;
    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_MOV = 4'h7;
    localparam logic [OP_W-1:0] OP_LDI = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP = 4'h9;
    localparam logic [OP_W-1:0] OP_JZ  = 4'hA;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;
    localparam logic [2:0]      FN_PASS = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_DECODE,
        S_EXEC,
        S_WAIT_ALU,
        S_WB,
        S_HALT
`ifdef CU_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t              state, state_nx;
    logic [DWIDTH-1:0]   ir;
    logic                zflag;
    logic [OP_W-1:0]     op;
    logic [REG_AW-1:0]   rd;
    logic                is_alu;
    state_t              after_instr;

    // State register, instruction register and zero flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ir    <= '0;
            zflag <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_WAIT_MEM && mem_rd_valid) ir <= mem_rdata;
            if (state == S_WAIT_ALU && alu_done) zflag <= alu_zero;
        end
    end

    // Next-state, IR field decode and state-decoded pulses
    always_comb begin
        state_nx   = state;
        mem_rd_req = 1'b0;
        alu_start  = 1'b0;
        alu_func   = 3'd0;
        alu_in_sel = 1'b0;
        reg_we     = '0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;

        op     = ir[DWIDTH-1 -: OP_W];
        rd     = ir[DWIDTH-OP_W-1 -: REG_AW];
        rs_sel = ir[DWIDTH-OP_W-REG_AW-1 -: REG_AW];
        imm    = ir[ADDR_W-1:0];
        is_alu = (op >= OP_ADD) && (op <= OP_LDI);

        if (op >= OP_ADD && op <= OP_MOV) alu_func = 3'(op - OP_ADD);
        else if (op == OP_LDI) alu_func = FN_PASS;
        alu_in_sel = (op == OP_LDI);

`ifdef CU_SINGLE_STEP_EN
        after_instr = S_PAUSE;
`else
        after_instr = en ? S_FETCH : S_IDLE;
`endif

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (en) state_nx = S_FETCH;
            end
            S_FETCH: begin
                mem_rd_req = 1'b1;
                state_nx   = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                if (mem_rd_valid) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu) begin
                    state_nx = S_EXEC;
                end else if (op == OP_HLT) begin
                    state_nx = S_HALT;
                end else begin
                    if (op == OP_JMP || (op == OP_JZ && zflag)) pc_load = 1'b1;
                    else pc_inc = 1'b1;
                    state_nx = after_instr;
                end
            end
            S_EXEC: begin
                alu_start = 1'b1;
                state_nx  = S_WAIT_ALU;
            end
            S_WAIT_ALU: begin
                if (alu_done) state_nx = S_WB;
            end
            S_WB: begin
                reg_we   = NREG'(1) << rd;
                pc_inc   = 1'b1;
                state_nx = after_instr;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
`ifdef CU_SINGLE_STEP_EN
            S_PAUSE: begin
                if (!en) state_nx = S_IDLE;
                else if (step) state_nx = S_FETCH;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit_seq.sv
// Self-checking bench for control_unit_seq: acts as instruction memory and ALU responder,
// predicting pulses from an instruction-level model of the opcode rules and zero flag.
module tb_control_unit_seq;

    logic        clk = 1'b0;
    logic        rst, en, mem_rd_valid, alu_done, alu_zero;
    logic [15:0] mem_rdata;
    logic        mem_rd_req, alu_start, alu_in_sel, pc_inc, pc_load, busy, halted;
    logic [2:0]  alu_func;
    logic [1:0]  rs_sel;
    logic [3:0]  reg_we;
    logic [7:0]  imm;
`ifdef CU_SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit zf    = 1'b0;
    int func_tab [16];

    control_unit_seq dut (
        .clk(clk), .rst(rst), .en(en),
`ifdef CU_SINGLE_STEP_EN
        .step(step),
`endif
        .mem_rd_req(mem_rd_req), .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata),
        .alu_start(alu_start), .alu_done(alu_done), .alu_zero(alu_zero),
        .alu_func(alu_func), .alu_in_sel(alu_in_sel), .rs_sel(rs_sel), .reg_we(reg_we),
        .imm(imm), .pc_inc(pc_inc), .pc_load(pc_load), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return mem_rd_req;
            1:       return alu_start;
            default: return |reg_we;
        endcase
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({mem_rd_req, alu_start, alu_func, alu_in_sel, rs_sel, reg_we, imm,
                    pc_inc, pc_load, busy, halted});
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n = 0;
        while (!sig(which) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sig(which)), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; mem_rd_valid = 1'b0; alu_done = 1'b0; alu_zero = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        zf  = 1'b0;
        @(negedge clk);
    endtask

    // One instruction through memory and (if needed) ALU handshakes; starts from a FETCH cycle.
    task automatic run_instr(input logic [15:0] ins, input int dm, input int da,
                             input logic z, input bit drop_en, output int lat);
        int t0;
        logic [3:0] op;
        bit alu;
        op  = ins[15:12];
        alu = (op >= 4'h1 && op <= 4'h8);
        wait_for(0, "fetch_req");
        t0 = cyc;
        @(negedge clk);
        if (drop_en) en = 1'b0;
        repeat (dm) @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_rdata    = ins;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        check("decode_busy", 32'(busy), 32'd1);
        check("decode_imm", 32'(imm), 32'(ins[7:0]));
        if (alu) begin
            check("decode_func", 32'(alu_func), 32'(func_tab[op]));
            check("decode_in_sel", 32'(alu_in_sel), 32'(op == 4'h8));
            check("decode_rs_sel", 32'(rs_sel), 32'(ins[9:8]));
            check("decode_pc", 32'({pc_inc, pc_load}), 32'd0);
            @(negedge clk);
            check("exec_start", 32'(alu_start), 32'd1);
            @(negedge clk);
            check("start_pulse", 32'(alu_start), 32'd0);
            repeat (da) @(negedge clk);
            alu_done = 1'b1;
            alu_zero = z;
            @(negedge clk);
            alu_done = 1'b0;
            alu_zero = 1'($urandom);
            check("wb_we", 32'(reg_we), 32'(4'b0001 << ins[11:10]));
            check("wb_pc_inc", 32'(pc_inc), 32'd1);
            check("wb_pc_load", 32'(pc_load), 32'd0);
            check("wb_func_stable", 32'(alu_func), 32'(func_tab[op]));
            zf = z;
        end else begin
            check("jmp_pc_load", 32'(pc_load), 32'(op == 4'h9 || (op == 4'hA && zf)));
            check("jmp_pc_inc", 32'(pc_inc), 32'(!(op == 4'h9 || (op == 4'hA && zf))));
        end
        @(negedge clk);
        lat = cyc - t0;
        check("post_clear", 32'({reg_we, pc_inc, pc_load, alu_start}), 32'd0);
        if (en) check("next_fetch", 32'(mem_rd_req), 32'd1);
        else    check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat, nreq;
        logic [3:0] rop;
        logic [15:0] rins;
        func_tab = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 0, 0, 0, 0, 0, 0, 0};
        mem_rdata = 16'h0;

        // reset state
        do_reset();
        check("reset_outs", all_outs(), 32'd0);

        // ADD r1,r2 with back-to-back handshakes: 6-cycle latency
        en = 1'b1;
        run_instr(16'h1600, 0, 0, 1'b0, 1'b0, lat);
        check("alu_latency", 32'(lat), 32'd6);
        run_instr(16'h8C5A, 1, 2, 1'b0, 1'b0, lat);

        // JZ taken after zero result, then not taken
        run_instr(16'h2400, 0, 1, 1'b1, 1'b0, lat);
        run_instr(16'hA010, 0, 0, 1'b0, 1'b0, lat);
        run_instr(16'h2400, 2, 0, 1'b0, 1'b0, lat);
        run_instr(16'hA010, 0, 0, 1'b0, 1'b0, lat);
        run_instr(16'h9077, 0, 0, 1'b0, 1'b0, lat);
        run_instr(16'hB123, 1, 0, 1'b0, 1'b0, lat);

        // randomized instruction stream (HLT excluded)
        for (int i = 0; i < 40; i++) begin
            rop  = 4'($urandom_range(0, 14));
            rins = {rop, 12'($urandom)};
            run_instr(rins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'b0, lat);
        end

        // en dropped while memory is slow: instruction completes, then IDLE
        run_instr(16'h3D00, 5, 1, 1'b0, 1'b1, lat);
        nreq = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_rd_req) nreq++;
        end
        check("en_drop_no_req", 32'(nreq), 32'd0);

        // reset in WAIT_ALU, late alu_done ignored
        en = 1'b1;
        wait_for(0, "rst_fetch");
        @(negedge clk);
        mem_rd_valid = 1'b1; mem_rdata = 16'h1600;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        @(negedge clk);
        check("rst_exec_start", 32'(alu_start), 32'd1);
        @(negedge clk);
        en = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; alu_done = 1'b1; alu_zero = 1'b1; zf = 1'b0;
        @(negedge clk);
        alu_done = 1'b0; alu_zero = 1'b0;
        check("rst_mid_outs", all_outs(), 32'd0);
        @(negedge clk);
        check("rst_mid_outs2", all_outs(), 32'd0);

        // zflag cleared by reset: JZ falls through
        en = 1'b1;
        run_instr(16'hA033, 0, 0, 1'b0, 1'b0, lat);

        // HLT: sticky halt, no fetches despite en
        wait_for(0, "hlt_fetch");
        @(negedge clk);
        mem_rd_valid = 1'b1; mem_rdata = 16'hF000;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        check("hlt_decode_pc", 32'({pc_inc, pc_load}), 32'd0);
        @(negedge clk);
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_busy", 32'(busy), 32'd0);
        nreq = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_rd_req) nreq++;
        end
        check("hlt_no_req", 32'(nreq), 32'd0);
        check("hlt_sticky", 32'(halted), 32'd1);
        do_reset();
        check("hlt_rst_clear", all_outs(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
